// File: rtl/fb_arbiter.sv
// Frame-buffer SDRAM arbiter: fetches display lines into a double-buffered
// line buffer with a bounded number of outstanding reads, and interleaves
// host write requests between line fetches.
module fb_arbiter #(
  parameter int          LINE_WORDS = 640,
  parameter logic [23:0] BASE_ADDR  = 24'h000000,
  parameter int          MAX_OUT    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_line_req,
  input  logic [9:0]  i_line_y,
  input  logic        i_wr_req,
  input  logic [23:0] i_wr_addr,
  input  logic [15:0] i_wr_data,
  output logic        o_wr_ack,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [23:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic        i_mem_rvalid,
  input  logic [15:0] i_mem_rdata,
  output logic        o_lb_we,
  output logic [9:0]  o_lb_addr,
  output logic [15:0] o_lb_data,
  output logic        o_lb_sel,
  output logic        o_line_done,
  output logic        o_underrun
);

  localparam int CW = $clog2(LINE_WORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE} state_t;

  state_t        r_state;
  logic          r_pend;
  logic [9:0]    r_y;
  logic [23:0]   r_line_addr;
  logic [CW-1:0] r_issued;
  logic [CW-1:0] r_wcnt;
  logic [2:0]    r_out;
  logic          r_last_wr;
  logic          r_wr_ack;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [23:0]   r_mem_addr;
  logic [15:0]   r_mem_wdata;
  logic          r_lb_we;
  logic [9:0]    r_lb_addr;
  logic [15:0]   r_lb_data;
  logic          r_lb_sel;
  logic          r_line_done;
  logic          r_underrun;

  logic          w_fetching;
  logic          w_acc;
  logic          w_rv;
  logic [CW-1:0] w_issued_nx;
  logic [2:0]    w_out_nx;
  logic [9:0]    w_y;
  logic [23:0]   w_line_addr;
  logic          w_rd_more;

  // Next-cycle read counters and the start address of a line about to be fetched.
  always_comb begin
    w_fetching  = (r_state == S_READ) || (r_state == S_DRAIN);
    w_acc       = (r_state == S_READ) && r_mem_req && i_mem_ack;
    w_rv        = w_fetching && i_mem_rvalid;
    w_issued_nx = r_issued + CW'(w_acc);
    case ({w_acc, w_rv})
      2'b10:   w_out_nx = r_out + 3'd1;
      2'b01:   w_out_nx = r_out - 3'd1;
      default: w_out_nx = r_out;
    endcase
    // A request arriving in the same cycle it is consumed takes precedence.
    if (i_line_req) begin
      w_y = i_line_y;
    end else begin
      w_y = r_y;
    end
    w_line_addr = BASE_ADDR + (24'(w_y) * 24'(LINE_WORDS));
    w_rd_more   = (w_issued_nx < CW'(LINE_WORDS)) && (w_out_nx < 3'(MAX_OUT));
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_pend      <= 1'b0;
      r_y         <= 10'd0;
      r_line_addr <= 24'd0;
      r_issued    <= '0;
      r_wcnt      <= '0;
      r_out       <= 3'd0;
      r_last_wr   <= 1'b0;
      r_wr_ack    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 24'd0;
      r_mem_wdata <= 16'd0;
      r_lb_we     <= 1'b0;
      r_lb_addr   <= 10'd0;
      r_lb_data   <= 16'd0;
      r_lb_sel    <= 1'b0;
      r_line_done <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_wr_ack    <= 1'b0;
      r_lb_we     <= 1'b0;
      r_line_done <= 1'b0;
      r_underrun  <= 1'b0;
      r_last_wr   <= 1'b0;

      if (i_line_req) begin
        r_pend <= 1'b1;
        r_y    <= i_line_y;
        if (w_fetching) begin
          r_underrun <= 1'b1;
        end
      end

      // Returned read data goes to the line buffer one cycle later.
      if (w_rv) begin
        r_lb_we   <= 1'b1;
        r_lb_data <= i_mem_rdata;
        r_lb_addr <= 10'(r_wcnt);
        r_wcnt    <= r_wcnt + CW'(1);
        r_last_wr <= (r_wcnt == CW'(LINE_WORDS - 1));
      end

      if (r_last_wr) begin
        r_line_done <= 1'b1;
        r_lb_sel    <= ~r_lb_sel;
      end

      case (r_state)
        S_IDLE: begin
          if (r_pend || i_line_req) begin
            r_state     <= S_READ;
            r_pend      <= 1'b0;
            r_line_addr <= w_line_addr;
            r_issued    <= '0;
            r_out       <= 3'd0;
            r_wcnt      <= '0;
            r_lb_addr   <= 10'd0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= w_line_addr;
          end else if (i_wr_req && !r_wr_ack) begin
            r_state     <= S_WRITE;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= i_wr_addr;
            r_mem_wdata <= i_wr_data;
          end else begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        S_READ: begin
          r_issued   <= w_issued_nx;
          r_out      <= w_out_nx;
          r_mem_req  <= w_rd_more;
          r_mem_addr <= r_line_addr + 24'(w_issued_nx);
          if (w_issued_nx == CW'(LINE_WORDS)) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_out     <= w_out_nx;
          r_mem_req <= 1'b0;
          if ((r_out == 3'd0) && (r_wcnt == CW'(LINE_WORDS))) begin
            r_state <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (i_mem_ack) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_wr_ack  <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign o_wr_ack    = r_wr_ack;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_lb_we     = r_lb_we;
  assign o_lb_addr   = r_lb_addr;
  assign o_lb_data   = r_lb_data;
  assign o_lb_sel    = r_lb_sel;
  assign o_line_done = r_line_done;
  assign o_underrun  = r_underrun;

endmodule

// File: tb/tb_fb_arbiter.sv
// Randomized bench for fb_arbiter: a behavioural SDRAM responder plus a
// line-level scoreboard (expected addresses from BASE + y*LINE_WORDS + k).
`timescale 1ns/1ps
module tb_fb_arbiter;
  localparam int          LW   = 640;
  localparam logic [23:0] BASE = 24'hFFFF00;
  localparam int          MO   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_rst = 1'b1, i_line_req = 1'b0, i_wr_req = 1'b0;
  logic [9:0]  i_line_y = 10'd0;
  logic [23:0] i_wr_addr = 24'd0;
  logic [15:0] i_wr_data = 16'd0;
  logic        i_mem_ack = 1'b0, i_mem_rvalid = 1'b0;
  logic [15:0] i_mem_rdata = 16'd0;
  logic        o_wr_ack, o_mem_req, o_mem_we, o_lb_we, o_lb_sel, o_line_done, o_underrun;
  logic [23:0] o_mem_addr;
  logic [15:0] o_mem_wdata, o_lb_data;
  logic [9:0]  o_lb_addr;

  fb_arbiter #(.LINE_WORDS(LW), .BASE_ADDR(BASE), .MAX_OUT(MO)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_line_req(i_line_req), .i_line_y(i_line_y),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_wr_ack(o_wr_ack), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .o_lb_we(o_lb_we),
    .o_lb_addr(o_lb_addr), .o_lb_data(o_lb_data), .o_lb_sel(o_lb_sel),
    .o_line_done(o_line_done), .o_underrun(o_underrun)
  );

  typedef struct { int due; logic [15:0] d; bit stale; } rv_t;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, m_out = 0, m_issued = 0, cur_y = 0, peak = 0;
  int exp_lines[$];
  logic [15:0] exp_lb[$];
  rv_t rvq[$];
  int lb_idx = 0, lines_done = 0, underrun_cnt = 0, wr_ack_cnt = 0, lbwe_cnt = 0;
  int total_acc = 0, wr_acc_cnt = 0, wr_acc_lines = 0, n_writes = 0;
  bit done_due = 1'b0;
  logic exp_sel = 1'b0;
  logic [23:0] wr_addr_e = 24'd0;
  logic [15:0] wr_data_e = 16'd0;
  int ack_pct = 100, ack_hold = 0, lat_min = 3, lat_max = 3, wait_cnt = 0, last_due = 0;
  logic p_req = 1'b0, p_we = 1'b0, p_ack = 1'b0, p_rv = 1'b0;
  bit p_stale = 1'b0;
  logic [23:0] p_addr = 24'd0;
  logic [15:0] p_wdata = 16'd0, p_rd = 16'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [23:0] exp_addr(input int y, input int k);
    int unsigned a;
    a = int'(BASE) + y * LW + k;
    return a[23:0];
  endfunction

  // Per-cycle responder, scoreboard and protocol monitor (runs on negedge).
  task automatic monitor();
    rv_t e;
    int lat;
    if (i_rst) begin
      m_out = 0; m_issued = 0; lb_idx = 0; done_due = 1'b0; exp_sel = 1'b0; wait_cnt = 0;
      exp_lb.delete();
      exp_lines.delete();
      for (int i = 0; i < rvq.size(); i++) rvq[i].stale = 1'b1;
    end else begin
      if (p_req && p_ack && !p_we) begin
        if (m_issued == 0) begin
          if (exp_lines.size() > 0) cur_y = exp_lines.pop_front();
          else chk("unexpected_fetch", 64'(p_addr), 64'hFFFF_FFFF);
        end
        chk("rd_addr", 64'(p_addr), 64'(exp_addr(cur_y, m_issued)));
        m_issued++; total_acc++; m_out++;
        if (m_issued == LW) m_issued = 0;
        lat = int'($urandom_range(lat_min, lat_max));
        e.due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        e.d = 16'($urandom);
        e.stale = 1'b0;
        rvq.push_back(e);
        last_due = e.due;
      end
      if (p_req && p_ack && p_we) begin
        chk("wr_addr", 64'(p_addr), 64'(wr_addr_e));
        chk("wr_data", 64'(p_wdata), 64'(wr_data_e));
        chk("wr_ack", 64'(o_wr_ack), 64'd1);
        wr_acc_cnt++;
        wr_acc_lines = lines_done;
      end
      if (p_rv && !p_stale) begin
        exp_lb.push_back(p_rd);
        m_out--;
      end
    end
    if (m_out > peak) peak = m_out;
    if (o_wr_ack) wr_ack_cnt++;
    if (o_underrun) underrun_cnt++;
    if (o_lb_we) lbwe_cnt++;
    if (done_due) begin
      chk("line_done", 64'(o_line_done), 64'd1);
      done_due = 1'b0;
      exp_sel = ~exp_sel;
      lines_done++;
      chk("lb_sel", 64'(o_lb_sel), 64'(exp_sel));
    end else if (o_line_done) begin
      chk("done_spurious", 64'(o_line_done), 64'd0);
    end
    if (o_lb_we) begin
      chk("lb_addr", 64'(o_lb_addr), 64'(lb_idx));
      if (exp_lb.size() > 0) chk("lb_data", 64'(o_lb_data), 64'(exp_lb.pop_front()));
      else chk("lb_spurious", 64'(o_lb_we), 64'd0);
      lb_idx++;
      if (lb_idx == LW) begin
        lb_idx = 0;
        done_due = 1'b1;
      end
    end
    if (!i_rst && p_req && !p_ack)
      chk("cmd_hold", 64'({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata}),
          64'({1'b1, p_we, p_addr, p_wdata}));
    if (m_out >= MO) chk("req_at_max", 64'(o_mem_req & ~o_mem_we), 64'd0);
    // Drive the responder inputs for the next rising edge.
    if (o_mem_req) begin
      if (wait_cnt >= ack_hold && int'($urandom_range(1, 100)) <= ack_pct) begin
        i_mem_ack = 1'b1; wait_cnt = 0;
      end else begin
        i_mem_ack = 1'b0; wait_cnt++;
      end
    end else begin
      i_mem_ack = 1'b0;
    end
    if (rvq.size() > 0 && rvq[0].due <= cyc) begin
      e = rvq.pop_front();
      i_mem_rvalid = 1'b1; i_mem_rdata = e.d; p_stale = e.stale;
    end else begin
      i_mem_rvalid = 1'b0; i_mem_rdata = 16'($urandom); p_stale = 1'b0;
    end
    p_req = o_mem_req; p_we = o_mem_we; p_addr = o_mem_addr; p_wdata = o_mem_wdata;
    p_ack = i_mem_ack; p_rv = i_mem_rvalid; p_rd = i_mem_rdata;
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_ctl"}, 64'({o_mem_req, o_mem_we, o_wr_ack, o_lb_we, o_line_done, o_underrun,
                             o_lb_sel, o_mem_addr, o_mem_wdata}), 64'd0);
    chk({tag, "_lb"}, 64'({o_lb_addr, o_lb_data}), 64'd0);
  endtask

  task automatic line_pulse(input int y);
    exp_lines.push_back(y);
    i_line_req = 1'b1; i_line_y = 10'(y);
    cycle();
    i_line_req = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (lines_done < target && n < 10000) begin cycle(); n++; end
    if (lines_done < target) chk("timeout_line", 64'(lines_done), 64'(target));
  endtask

  task automatic wait_wr_ack(input int budget);
    int n0 = wr_ack_cnt;
    int k = 0;
    while (wr_ack_cnt == n0 && k < budget) begin cycle(); k++; end
    i_wr_req = 1'b0;
    if (wr_ack_cnt == n0) chk("timeout_wr", 64'(wr_ack_cnt), 64'(n0 + 1));
  endtask

  task automatic do_write(input logic [23:0] a, input logic [15:0] d);
    wr_addr_e = a; wr_data_e = d; n_writes++;
    i_wr_req = 1'b1; i_wr_addr = a; i_wr_data = d;
    wait_wr_ack(500);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, ld, k;
    repeat (3) cycle();
    outs_zero("reset");
    i_rst = 1'b0;
    cycle();

    // Basic line fetch, y=2, ack every cycle, fixed latency.
    a0 = total_acc;
    line_pulse(2);
    wait_done(1);
    chk("line1_acc", 64'(total_acc - a0), 64'(LW));
    chk("line1_sel", 64'(o_lb_sel), 64'd1);

    // Slow acks and long latency to reach the outstanding limit.
    ack_hold = 5; lat_min = 20; lat_max = 20; peak = 0;
    line_pulse(1);
    wait_done(2);
    chk("peak_out", 64'(peak), 64'(MO));
    ack_hold = 0; lat_min = 3; lat_max = 3;

    // Line and write requested together: line first, write after done.
    repeat (2) cycle();
    ld = lines_done;
    exp_lines.push_back(3);
    wr_addr_e = 24'h123456; wr_data_e = 16'hBEEF; n_writes++;
    i_wr_req = 1'b1; i_wr_addr = 24'h123456; i_wr_data = 16'hBEEF;
    i_line_req = 1'b1; i_line_y = 10'd3;
    cycle();
    i_line_req = 1'b0;
    wait_wr_ack(6000);
    chk("wr_after_line", 64'(wr_acc_lines), 64'(ld + 1));
    repeat (3) cycle();
    chk("wr_ack_single", 64'(wr_ack_cnt), 64'(n_writes));

    // Underrun: y=5 requested during fetch of y=4.
    ack_pct = 70; lat_min = 1; lat_max = 8;
    line_pulse(4);
    k = 0;
    while (m_issued < 100 && k < 2000) begin cycle(); k++; end
    exp_lines.push_back(5);
    i_line_req = 1'b1; i_line_y = 10'd5;
    cycle();
    i_line_req = 1'b0;
    cycle();
    chk("underrun", 64'(underrun_cnt), 64'd1);
    wait_done(ld + 3);

    // Randomized lines interleaved with host writes.
    for (int it = 0; it < 3; it++) begin
      ack_pct = int'($urandom_range(50, 100));
      lat_max = int'($urandom_range(1, 6));
      line_pulse(int'($urandom_range(0, 1023)));
      wait_done(lines_done + 1);
      do_write(24'($urandom), 16'($urandom));
    end

    // Reset mid-fetch, late returns ignored, then fresh fetch of y=0.
    ack_pct = 100; lat_min = 10; lat_max = 10;
    line_pulse(6);
    k = 0;
    while (m_issued < 100 && k < 2000) begin cycle(); k++; end
    i_rst = 1'b1;
    cycle();
    outs_zero("midreset");
    i_rst = 1'b0;
    a0 = lbwe_cnt;
    k = 0;
    while (rvq.size() > 0 && k < 200) begin cycle(); k++; end
    repeat (2) cycle();
    chk("late_lbwe", 64'(lbwe_cnt - a0), 64'd0);
    ld = lines_done;
    a0 = total_acc;
    line_pulse(0);
    wait_done(ld + 1);
    chk("fresh_acc", 64'(total_acc - a0), 64'(LW));
    chk("fresh_sel", 64'(o_lb_sel), 64'd1);

    repeat (5) cycle();
    chk("underrun_total", 64'(underrun_cnt), 64'd1);
    chk("wr_ack_total", 64'(wr_ack_cnt), 64'(n_writes));
    chk("wr_acc_total", 64'(wr_acc_cnt), 64'(n_writes));
    chk("lines_left", 64'(exp_lines.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter LINE_WORDS, default 640, 16-bit words fetched per display line.
REQ-002 Parameter BASE_ADDR, default 24'h000000, SDRAM word address of frame line 0.
REQ-003 Parameter MAX_OUT, default 4, max outstanding read requests (1..7).
REQ-004 i_clk  in  1  single clock; all logic on its rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_line_req  in  1  one-cycle pulse: fetch display line i_line_y.
REQ-007 i_line_y  in  10  line number, sampled with i_line_req.
REQ-008 i_wr_req, i_wr_addr[23:0], i_wr_data[15:0]  in  host write request; held stable until o_wr_ack.
REQ-009 o_wr_ack  out  1  one-cycle pulse: host write accepted by SDRAM.
REQ-010 o_mem_req, o_mem_we, o_mem_addr[23:0], o_mem_wdata[15:0]  out  SDRAM controller command port.
REQ-011 i_mem_ack  in  1  controller accepts the current command this cycle.
REQ-012 i_mem_rvalid, i_mem_rdata[15:0]  in  read data return, in issue order, one word per rvalid.
REQ-013 o_lb_we, o_lb_addr[9:0], o_lb_data[15:0], o_lb_sel  out  line-buffer write port; o_lb_sel selects half of a double buffer.
REQ-014 o_line_done  out  1  one-cycle pulse: last word of the line written.
REQ-015 o_underrun  out  1  one-cycle pulse: line request arrived while a fetch was active.

Function
REQ-016 States IDLE, READ, DRAIN, WRITE; reset -> IDLE.
REQ-017 IDLE: pending line request -> READ (priority); else i_wr_req high and o_wr_ack low -> WRITE; else stay.
REQ-018 Line request latching: i_line_req sets pending flag and stores y; a second request before fetch start overwrites y.
REQ-019 READ entry: line address = BASE_ADDR + y*LINE_WORDS (24-bit, wraps modulo 2^24); issue counter, outstanding counter and o_lb_addr cleared; pending flag cleared.
REQ-020 READ: o_mem_req=1, o_mem_we=0 while issued < LINE_WORDS and outstanding < MAX_OUT; o_mem_addr = line address + issued.
REQ-021 Once o_mem_req is asserted, command fields shall stay stable until i_mem_ack.
REQ-022 Outstanding: +1 on read accept, -1 on i_mem_rvalid, unchanged when both in the same cycle; never exceeds MAX_OUT.
REQ-023 READ -> DRAIN when issued reaches LINE_WORDS; DRAIN -> IDLE when outstanding = 0 and all LINE_WORDS words written.
REQ-024 Each i_mem_rvalid in READ/DRAIN: next cycle o_lb_we=1, o_lb_data=captured rdata, o_lb_addr=word index (0..LINE_WORDS-1); index increments after each write.
REQ-025 Cycle after the last line-buffer write: o_line_done=1 for one cycle and o_lb_sel toggles.
REQ-026 i_line_req in READ or DRAIN: o_underrun=1 next cycle; request latched per REQ-018, started after return to IDLE.
REQ-027 i_mem_rvalid in IDLE or WRITE is ignored (no lb write, no counter change).
REQ-028 WRITE: o_mem_req=1, o_mem_we=1, o_mem_addr=i_wr_addr, o_mem_wdata=i_wr_data; on i_mem_ack -> IDLE and o_wr_ack=1 next cycle.
REQ-029 A write in WRITE is never aborted; a line request arriving then waits for ack.
REQ-030 While o_wr_ack=1, i_wr_req shall not start a new write (host deasserts or presents next request).
REQ-031 o_mem_req=0 in IDLE and DRAIN.

Reset
REQ-032 i_rst high at a clock edge: state IDLE, all counters, pending flag and stored y = 0, o_lb_sel=0.
REQ-033 Reset values of all outputs: o_mem_req, o_mem_we, o_wr_ack, o_lb_we, o_line_done, o_underrun = 0; o_mem_addr, o_mem_wdata, o_lb_addr, o_lb_data = 0.
REQ-034 Reset mid-fetch abandons the line; later rvalids for it are ignored per REQ-027.

Verification
REQ-035 LINE_WORDS=640, y=2, ack every cycle, rvalid 3 cycles after ack -> addresses 1280..1919 in order, 640 lb writes addr 0..639, o_line_done once, o_lb_sel 0->1.
REQ-036 Ack withheld 5 cycles, rvalid delay 20 -> outstanding peaks at MAX_OUT=4, o_mem_req low while at 4, addr/req stable while unacked.
REQ-037 i_wr_req and i_line_req same cycle in IDLE -> READ first; write issued after o_line_done, o_wr_ack single pulse.
REQ-038 i_line_req for y=5 during fetch of y=4 -> o_underrun pulse; after y=4 completes, y=5 fetched from BASE_ADDR+3200.
REQ-039 i_rst asserted after 100 reads issued -> all outputs 0 next cycle, late rvalids produce no o_lb_we, fresh i_line_req y=0 fetches from BASE_ADDR.
REQ-040 BASE_ADDR=24'hFFFF00, y=0 -> o_mem_addr wraps from 24'hFFFFFF to 24'h000000.
